// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one combinational memory port.
// Round-robin grant, fixed strobe length, registered read data and ack.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] mem_dir,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wd,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [1:0]        grant
);

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
    end
  endgenerate

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              we_q;
  logic              last_q;
  logic [ADDR_W-1:0] dir_q;
  logic [DATA_W-1:0] wdat_q;
  logic              rd_q;
  logic              wd_q;
  logic [1:0]        ack_q;
  logic [1:0]        grant_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              pick1;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that did not win last time is picked.
  always_comb begin
    pick1     = m1_req && (!m0_req || !last_q);
    any_req   = m0_req || m1_req;
    sel_we    = pick1 ? m1_we    : m0_we;
    sel_addr  = pick1 ? m1_addr  : m0_addr;
    sel_wdata = pick1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      dir_q    <= '0;
      wdat_q   <= '0;
      rd_q     <= 1'b0;
      wd_q     <= 1'b0;
      ack_q    <= 2'b00;
      grant_q  <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_q   <= 2'b00;
          grant_q <= 2'b00;
          if (any_req) begin
            dir_q   <= sel_addr;
            wdat_q  <= sel_wdata;
            we_q    <= sel_we;
            rd_q    <= ~sel_we;
            wd_q    <= sel_we;
            grant_q <= pick1 ? 2'b10 : 2'b01;
            last_q  <= pick1;
            cnt_q   <= CW'(WAIT_CYCLES - 1);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            rd_q    <= 1'b0;
            wd_q    <= 1'b0;
            ack_q   <= grant_q;
            state_q <= DONE;
            if (!we_q) begin
              if (grant_q[1]) rdata1_q <= mem_data_out;
              else            rdata0_q <= mem_data_out;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          ack_q   <= 2'b00;
          grant_q <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_dir     = dir_q;
  assign mem_data_in = wdat_q;
  assign mem_rd      = rd_q;
  assign mem_wd      = wd_q;
  assign m0_ack      = ack_q[0];
  assign m1_ack      = ack_q[1];
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, WAIT_CYCLES=2.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic [31:0] mem_dir, mem_data_in, mem_data_out;
  logic        mem_rd, mem_wd;
  logic [1:0]  grant;
  logic        use_fn = 1'b0;
  logic [31:0] mem_val = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: either a fixed word or the inverted address.
  always_comb mem_data_out = use_fn ? ~mem_dir : mem_val;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_dir(mem_dir), .mem_data_in(mem_data_in),
    .mem_rd(mem_rd), .mem_wd(mem_wd),
    .mem_data_out(mem_data_out), .grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dir"}, mem_dir, 32'h0);
    chk({tag, ".din"}, mem_data_in, 32'h0);
    chk({tag, ".strb"}, {30'h0, mem_rd, mem_wd}, 32'h0);
    chk({tag, ".ack"}, {30'h0, m1_ack, m0_ack}, 32'h0);
    chk({tag, ".gnt"}, {30'h0, grant}, 32'h0);
    chk({tag, ".rd0"}, m0_rdata, 32'h0);
    chk({tag, ".rd1"}, m1_rdata, 32'h0);
  endtask

  initial begin
    int n;
    #2;
    chk_all_zero("rst");
    step();
    reset = 1'b0;
    step();
    chk({30'h0, grant}, 32'h0, 32'h0) ;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    @(negedge reset);
    step();

    // m0 read of 0x10
    mem_val = 32'hDEADBEEF;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    step();
    chk("t1.c1.rd", {31'h0, mem_rd}, 32'h1);
    chk("t1.c1.wd", {31'h0, mem_wd}, 32'h0);
    chk("t1.c1.dir", mem_dir, 32'h10);
    chk("t1.c1.gnt", {30'h0, grant}, 32'h1);
    chk("t1.c1.ack", {30'h0, m1_ack, m0_ack}, 32'h0);
    step();
    chk("t1.c2.rd", {31'h0, mem_rd}, 32'h1);
    chk("t1.c2.ack", {30'h0, m1_ack, m0_ack}, 32'h0);
    step();
    chk("t1.c3.strb", {30'h0, mem_rd, mem_wd}, 32'h0);
    chk("t1.c3.ack", {30'h0, m1_ack, m0_ack}, 32'h1);
    chk("t1.c3.rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1.c3.gnt", {30'h0, grant}, 32'h1);
    m0_req = 1'b0;
    step();
    chk("t1.idle.ack", {30'h0, m1_ack, m0_ack}, 32'h0);
    chk("t1.idle.gnt", {30'h0, grant}, 32'h0);
    chk("t1.idle.dir", mem_dir, 32'h10);
    step();
    chk("t1.idle2.gnt", {30'h0, grant}, 32'h0);

    // m1 write of 0x12345678 to 0x20
    mem_val = 32'hCAFEF00D;
    m1_req = 1'b1; m1_we = 1'b1;
    m1_addr = 32'h20; m1_wdata = 32'h12345678;
    step();
    chk("t2.c1.wd", {31'h0, mem_wd}, 32'h1);
    chk("t2.c1.rd", {31'h0, mem_rd}, 32'h0);
    chk("t2.c1.din", mem_data_in, 32'h12345678);
    chk("t2.c1.dir", mem_dir, 32'h20);
    chk("t2.c1.gnt", {30'h0, grant}, 32'h2);
    step();
    chk("t2.c2.strb", {30'h0, mem_rd, mem_wd}, 32'h1);
    step();
    chk("t2.c3.strb", {30'h0, mem_rd, mem_wd}, 32'h0);
    chk("t2.c3.ack", {30'h0, m1_ack, m0_ack}, 32'h2);
    chk("t2.c3.rd1", m1_rdata, 32'h0);
    chk("t2.c3.rd0", m0_rdata, 32'hDEADBEEF);
    m1_req = 1'b0;
    step();
    chk("t2.idle.gnt", {30'h0, grant}, 32'h0);

    // fresh reset, then both request continuously
    reset = 1'b1;
    step();
    reset = 1'b0;
    use_fn = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
    step();
    chk("t3.first.gnt", {30'h0, grant}, 32'h1);
    n = 1;
    for (int i = 0; i < 8; i++) begin
      while (!(m0_ack || m1_ack) && n < 12) begin
        chk("t4.excl", {30'h0, mem_rd, mem_wd}, {30'h0, mem_rd, 1'b0});
        step();
        n++;
      end
      chk("t4.gap", 32'(n), (i == 0) ? 32'd3 : 32'd4);
      chk("t4.order", {30'h0, m1_ack, m0_ack},
          (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i % 2 == 0) chk("t4.rd0", m0_rdata, ~32'h40);
      else            chk("t4.rd1", m1_rdata, ~32'h44);
      if (i == 7) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      step();
      n = 1;
    end
    step();
    chk("t4.end.gnt", {30'h0, grant}, 32'h0);

    // reset in the middle of an m1 write
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h80;
    m1_wdata = 32'h55AA55AA;
    step();
    chk("t5.pre.wd", {31'h0, mem_wd}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("t5.async");
    step();
    chk("t5.held.ack", {30'h0, m1_ack, m0_ack}, 32'h0);
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h90;
    step();
    chk("t5.tie.gnt", {30'h0, grant}, 32'h1);
    step();
    step();
    chk("t5.ack", {30'h0, m1_ack, m0_ack}, 32'h1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    step();
    chk("t5.idle.gnt", {30'h0, grant}, 32'h0);

    // m0 drops req during second access cycle
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hA0;
    step();
    step();
    m0_req = 1'b0;
    chk("t6.c2.rd", {31'h0, mem_rd}, 32'h1);
    step();
    chk("t6.c3.ack", {30'h0, m1_ack, m0_ack}, 32'h1);
    chk("t6.c3.rd0", m0_rdata, ~32'hA0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (m0_ack || m1_ack || grant != 2'b00) n++;
    end
    chk("t6.quiet", 32'(n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
